// File: rtl/apb_slave_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : apb_slave_responder_if
// Description : APB4 bus bundle between a requester and apb_slave_responder.
//               Carries select/enable/direction, address, write data, byte
//               strobes and protection from the requester, plus ready, read
//               data and error from the completer.
//               Modports: master (requester side), slave (completer side).
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_slave_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [2:0]              pprot;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output pready, prdata, pslverr
    );
endinterface
`default_nettype wire

// File: rtl/apb_slave_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : apb_slave_responder
// Description : APB4 completer with a small word-addressed register memory,
//               a fixed number of wait states per access phase and an error
//               response for out-of-range or misaligned addresses.
// Ports       : pclk     - APB clock, rising edge
//               preset_n - asynchronous active-low reset
//               apb      - APB bus, slave modport (psel, penable, pwrite,
//                          paddr, pwdata, pstrb, pprot in; pready, prdata,
//                          pslverr out, all outputs registered)
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_responder #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                 pclk,
    input  logic                 preset_n,
    apb_slave_responder_if.slave apb
);
    localparam int                  c_nbytes = DATA_WIDTH / 8;
    localparam int                  c_lsb    = (c_nbytes > 1) ? $clog2(c_nbytes) : 0;
    localparam int                  c_idx_w  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] c_span   = (ADDR_WIDTH + 1)'(MEM_DEPTH * c_nbytes);
    localparam logic [3:0]          c_ws     = 4'(WAIT_STATES);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_nxt;
    logic                    r_pready;
    logic                    w_pready_nxt;
    logic [DATA_WIDTH-1:0]   r_prdata;
    logic [DATA_WIDTH-1:0]   w_prdata_nxt;
    logic                    r_pslverr;
    logic                    w_pslverr_nxt;
    logic                    w_capture;
    logic                    w_commit;

    // Transfer attributes latched on the setup edge
    logic                    r_write;
    logic                    r_err;
    logic [c_idx_w-1:0]      r_idx;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [c_nbytes-1:0]     r_strb;

    logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

    // Address decode of the live bus address; one extra bit so that an
    // address below BASE_ADDR or past the window can never wrap into range.
    logic [ADDR_WIDTH:0]     w_off;
    logic                    w_below;
    logic                    w_misalign;
    logic                    w_err;
    logic [c_idx_w-1:0]      w_idx;
    logic                    w_unused;

    assign w_off   = {1'b0, apb.paddr} - {1'b0, BASE_ADDR};
    assign w_below = apb.paddr < BASE_ADDR;
    assign w_idx   = w_off[c_lsb +: c_idx_w];

    generate
        if (c_lsb > 0) begin : g_align
            assign w_misalign = |apb.paddr[c_lsb-1:0];
        end else begin : g_no_align
            assign w_misalign = 1'b0;
        end
    endgenerate

    assign w_err    = w_below | (w_off >= c_span) | w_misalign;
    assign w_unused = ^apb.pprot;

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pready_nxt  = r_pready;
        w_prdata_nxt  = r_prdata;
        w_pslverr_nxt = r_pslverr;
        w_capture     = 1'b0;
        w_commit      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // penable without a preceding setup cycle is ignored here
                if (apb.psel && !apb.penable) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_ACCESS;
                    w_cnt_nxt   = c_ws;
                    // With no wait states the first access cycle already
                    // completes, so the response is produced on the setup edge.
                    if (c_ws == 4'd0) begin
                        w_pready_nxt  = 1'b1;
                        w_pslverr_nxt = w_err;
                        w_prdata_nxt  = (!apb.pwrite && !w_err) ? r_mem[w_idx] : '0;
                    end
                end
            end
            ST_ACCESS: begin
                if (!apb.psel) begin
                    // Abort: drop back without touching memory
                    w_state_nxt   = ST_IDLE;
                    w_cnt_nxt     = 4'd0;
                    w_pready_nxt  = 1'b0;
                    w_prdata_nxt  = '0;
                    w_pslverr_nxt = 1'b0;
                end else if (apb.penable && r_pready) begin
                    w_commit      = r_write && !r_err;
                    w_state_nxt   = ST_IDLE;
                    w_cnt_nxt     = 4'd0;
                    w_pready_nxt  = 1'b0;
                    w_prdata_nxt  = '0;
                    w_pslverr_nxt = 1'b0;
                end else if (apb.penable && (r_cnt != 4'd0)) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_pready_nxt  = 1'b1;
                        w_pslverr_nxt = r_err;
                        w_prdata_nxt  = (!r_write && !r_err) ? r_mem[r_idx] : '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_pready  <= 1'b0;
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pready  <= w_pready_nxt;
            r_prdata  <= w_prdata_nxt;
            r_pslverr <= w_pslverr_nxt;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_strb  <= '0;
        end else if (w_capture) begin
            r_write <= apb.pwrite;
            r_err   <= w_err;
            r_idx   <= w_idx;
            r_wdata <= apb.pwdata;
            r_strb  <= apb.pstrb;
        end
    end

    // Byte-lane write on the completion edge
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            for (int b = 0; b < c_nbytes; b++) begin
                if (r_strb[b]) begin
                    r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    assign apb.pready  = r_pready;
    assign apb.prdata  = r_prdata;
    assign apb.pslverr = r_pslverr;
endmodule
`default_nettype wire

// File: tb/tb_apb_slave_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_apb_slave_responder
// Description : Testbench for apb_slave_responder. Three instances with
//               WAIT_STATES 0, 3 and 2 share one set of driven bus signals;
//               psel is routed to the instance picked by sel. Responses are
//               compared with a word-array model of the register memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_slave_responder;
    logic        pclk = 1'b0;
    logic        preset_n = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    int          sel = 0;

    logic        rdy;
    logic        err;
    logic [31:0] rdata;

    logic [31:0] model_mem [3][16];
    int          ws_of [3] = '{0, 3, 2};
    int          checks = 0;
    int          passed = 0;
    int          failed = 0;

    always #5 pclk = ~pclk;

    apb_slave_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    apb_slave_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
    apb_slave_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

    assign bus0.psel = psel && (sel == 0);
    assign bus1.psel = psel && (sel == 1);
    assign bus2.psel = psel && (sel == 2);
    assign bus0.penable = penable;
    assign bus1.penable = penable;
    assign bus2.penable = penable;
    assign bus0.pwrite = pwrite;
    assign bus1.pwrite = pwrite;
    assign bus2.pwrite = pwrite;
    assign bus0.paddr = paddr;
    assign bus1.paddr = paddr;
    assign bus2.paddr = paddr;
    assign bus0.pwdata = pwdata;
    assign bus1.pwdata = pwdata;
    assign bus2.pwdata = pwdata;
    assign bus0.pstrb = pstrb;
    assign bus1.pstrb = pstrb;
    assign bus2.pstrb = pstrb;
    assign bus0.pprot = 3'b000;
    assign bus1.pprot = 3'b010;
    assign bus2.pprot = 3'b111;

    apb_slave_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(16),
                          .BASE_ADDR(32'h0), .WAIT_STATES(0))
        dut0 (.pclk(pclk), .preset_n(preset_n), .apb(bus0));
    apb_slave_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(16),
                          .BASE_ADDR(32'h0), .WAIT_STATES(3))
        dut1 (.pclk(pclk), .preset_n(preset_n), .apb(bus1));
    apb_slave_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(16),
                          .BASE_ADDR(32'h0), .WAIT_STATES(2))
        dut2 (.pclk(pclk), .preset_n(preset_n), .apb(bus2));

    always_comb begin
        rdy   = bus0.pready;
        err   = bus0.pslverr;
        rdata = bus0.prdata;
        case (sel)
            1: begin rdy = bus1.pready; err = bus1.pslverr; rdata = bus1.prdata; end
            2: begin rdy = bus2.pready; err = bus2.pslverr; rdata = bus2.prdata; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // 64-byte window at address 0, word aligned
    function automatic bit m_err(input logic [31:0] a);
        return (a >= 32'h40) || (a[1:0] != 2'b00);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 3; s++)
            for (int w = 0; w < 16; w++)
                model_mem[s][w] = '0;
    endtask

    // Called at a negedge; returns at the negedge after the completion edge.
    task automatic xfer(input int s, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] st,
                        output logic [31:0] got);
        int          lat;
        bit          e;
        logic [31:0] exp_rd;
        e      = m_err(a);
        exp_rd = (!wr && !e) ? model_mem[s][a[5:2]] : 32'h0;
        sel = s; psel = 1'b1; penable = 1'b0;
        pwrite = wr; paddr = a; pwdata = d; pstrb = st;
        @(negedge pclk);
        penable = 1'b1;
        lat = 0;
        while (rdy !== 1'b1 && lat < 40) begin
            @(negedge pclk);
            lat++;
        end
        check("latency", 32'(lat), 32'(ws_of[s]));
        check("pslverr", {31'b0, err}, {31'b0, e});
        check("prdata", rdata, exp_rd);
        got = rdata;
        if (wr && !e) begin
            for (int b = 0; b < 4; b++)
                if (st[b]) model_mem[s][a[5:2]][8*b +: 8] = d[8*b +: 8];
        end
        @(negedge pclk);
        check("post_ready_err", {30'b0, rdy, err}, 32'h0);
        check("post_prdata", rdata, 32'h0);
    endtask

    task automatic idle(input int n);
        psel = 1'b0;
        penable = 1'b0;
        repeat (n) @(negedge pclk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        model_reset();
        repeat (3) @(negedge pclk);
        preset_n = 1'b1;
        @(negedge pclk);

        // Reset state of every instance
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("reset_outputs", {30'b0, rdy, err}, 32'h0);
            check("reset_prdata", rdata, 32'h0);
        end
        @(negedge pclk);

        // Full-word write then read, no wait states
        xfer(0, 1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, got);
        xfer(0, 1'b0, 32'h8, 32'h0, 4'hF, got);
        check("rd_0x8", got, 32'hDEAD_BEEF);

        // Partial strobe merge
        xfer(0, 1'b1, 32'h0, 32'h1122_3344, 4'hF, got);
        xfer(0, 1'b1, 32'h0, 32'hAABB_CCDD, 4'b0101, got);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, got);
        check("pstrb_0101", got, 32'h11BB_33DD);

        // Errors leave memory alone; pstrb=0 write changes nothing
        xfer(0, 1'b1, 32'h4, 32'h0102_0304, 4'hF, got);
        xfer(0, 1'b0, 32'h40, 32'h0, 4'hF, got);
        xfer(0, 1'b1, 32'h6, 32'hFFFF_FFFF, 4'hF, got);
        xfer(0, 1'b1, 32'h4, 32'hFFFF_FFFF, 4'h0, got);
        xfer(0, 1'b0, 32'h4, 32'h0, 4'hF, got);
        check("err_mem_kept", got, 32'h0102_0304);

        // Three wait states, back-to-back transfers
        xfer(1, 1'b1, 32'hC, 32'hCAFE_F00D, 4'hF, got);
        xfer(1, 1'b0, 32'hC, 32'h0, 4'hF, got);
        xfer(1, 1'b0, 32'hC, 32'h0, 4'hF, got);
        check("ws3_rd_0xC", got, 32'hCAFE_F00D);

        // Abort with two wait states: drop psel in the second access cycle
        xfer(2, 1'b1, 32'h10, 32'h5555_AAAA, 4'hF, got);
        sel = 2; psel = 1'b1; penable = 1'b0;
        pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
        check("abort_ready_t2", {31'b0, rdy}, 32'h0);
        repeat (3) begin
            @(negedge pclk);
            check("abort_ready", {31'b0, rdy}, 32'h0);
        end
        xfer(2, 1'b0, 32'h10, 32'h0, 4'hF, got);
        check("abort_mem_kept", got, 32'h5555_AAAA);

        // penable without a setup cycle gets no response
        sel = 2; psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h10;
        repeat (5) begin
            @(negedge pclk);
            check("nosetup_ready", {31'b0, rdy}, 32'h0);
        end
        idle(1);

        // Random traffic across all instances
        for (int i = 0; i < 60; i++) begin
            int          s;
            bit          wr;
            logic [31:0] a;
            s  = int'($urandom_range(0, 2));
            wr = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 19)) * 32'd4;
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            xfer(s, wr, a, $urandom, 4'($urandom_range(0, 15)), got);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(0, 2)));
        end

        // Reset while the response is being presented
        xfer(0, 1'b1, 32'h4, 32'h1234_5678, 4'hF, got);
        sel = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h4;
        @(negedge pclk);
        penable = 1'b1;
        check("pre_reset_ready", {31'b0, rdy}, 32'h1);
        check("pre_reset_prdata", rdata, 32'h1234_5678);
        #2;
        preset_n = 1'b0;
        #1;
        check("async_reset_outputs", {30'b0, rdy, err}, 32'h0);
        check("async_reset_prdata", rdata, 32'h0);
        model_reset();
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        preset_n = 1'b1;
        @(negedge pclk);
        xfer(0, 1'b0, 32'h4, 32'h0, 4'hF, got);
        check("post_reset_rd_0x4", got, 32'h0);
        idle(2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
`default_nettype wire
